cpu_run_ctrl: RTL and testbench

Host-side sequencer for the 5-stage pipelined CPU.
- Streams a program into instruction memory through the external port.
- Holds the CPU in reset, then releases it and runs it for a programmed number of cycles with `enable` high.
- Freezes the CPU and streams a programmed window of data memory back to the host.
- Sits between the testbench/host interface and the CPU's `*_ext` ports and `enable` pin.

---
 rtl/cpu_run_ctrl_pkg.sv | 16 +
 rtl/down_counter.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: sequencer state encoding.
package cpu_run_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_REQ,
    DUMP_WAIT,
    DUMP_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side sequencer: loads a program into imem, runs the CPU for a fixed
// cycle budget, then freezes it and streams a window of dmem back out.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_AW = 9,
  parameter int unsigned DMEM_AW = 10,
  parameter int unsigned CYC_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CYC_W-1:0]   run_cycles,
  input  logic [DMEM_AW:0]   dump_len,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               cpu_rst_n,
  output logic               cpu_enable,
  output logic [31:0]        imem_addr,
  output logic               imem_wen,
  output logic [31:0]        imem_wdata,
  output logic [31:0]        dmem_addr,
  output logic               dmem_ren,
  input  logic [31:0]        dmem_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [31:0]        dump_data,
  output logic               busy,
  output logic               done,
  output logic               load_ovf
);

  localparam logic [DMEM_AW:0] DMEM_DEPTH = {1'b1, {DMEM_AW{1'b0}}};

  state_t               state;
  state_t               nxt;
  logic [IMEM_AW-1:0]   load_ptr;
  logic [DMEM_AW-1:0]   dump_ptr;
  logic [DMEM_AW:0]     dump_len_clamped;
  logic                 start_ok;
  logic                 load_hs;
  logic                 load_exit;
  logic                 dump_hs;
  logic                 run_dec;
  logic                 run_zero;
  logic                 dmp_dec;
  logic                 dmp_zero;

  assign start_ok         = start && ((state == IDLE) || (state == DONE));
  assign load_hs          = load_valid && load_ready;
  assign load_exit        = load_hs && (load_last || (load_ptr == '1));
  assign dump_hs          = dump_valid && dump_ready;
  assign dump_len_clamped = (dump_len > DMEM_DEPTH) ? DMEM_DEPTH : dump_len;

  // The run budget is taken on the LOAD exit edge, so RUN lasts exactly
  // run_cycles cycles; the dump count drops in DUMP_REQ and is therefore
  // already "words left after this one" when DUMP_OUT decides where to go.
  assign run_dec = ((state == LOAD) && load_exit) || (state == RUN);
  assign dmp_dec = (state == DUMP_REQ);

  down_counter #(.W(CYC_W)) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val (run_cycles),
    .dec      (run_dec),
    .zero     (run_zero)
  );

  down_counter #(.W(DMEM_AW + 1)) u_dump_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val (dump_len_clamped),
    .dec      (dmp_dec),
    .zero     (dmp_zero)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = LOAD;
      LOAD:       if (load_exit) nxt = run_zero ? DUMP_REQ : RUN;
      RUN:        if (run_zero) nxt = DUMP_REQ;
      DUMP_REQ:   nxt = dmp_zero ? DONE : DUMP_WAIT;
      DUMP_WAIT:  nxt = DUMP_OUT;
      DUMP_OUT:   if (dump_hs) nxt = dmp_zero ? DONE : DUMP_REQ;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_ptr   <= '0;
      dump_ptr   <= '0;
      dump_data  <= '0;
      load_ovf   <= 1'b0;
      load_ready <= 1'b0;
      cpu_rst_n  <= 1'b0;
      cpu_enable <= 1'b0;
      dmem_ren   <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      load_ready <= (nxt == LOAD);
      cpu_rst_n  <= nxt inside {RUN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE};
      cpu_enable <= (nxt == RUN);
      // The dump count is stable on every path into DUMP_REQ.
      dmem_ren   <= (nxt == DUMP_REQ) && !dmp_zero;
      dump_valid <= (nxt == DUMP_OUT);
      done       <= (nxt == DONE);
      busy       <= !(nxt inside {IDLE, DONE});

      if (start_ok) begin
        load_ptr <= '0;
        dump_ptr <= '0;
        load_ovf <= 1'b0;
      end

      if ((state == LOAD) && load_hs) begin
        load_ptr <= load_ptr + IMEM_AW'(1);
        if ((load_ptr == '1) && !load_last) load_ovf <= 1'b1;
      end

      if (state == DUMP_WAIT) dump_data <= dmem_rdata;

      if ((state == DUMP_OUT) && dump_hs) dump_ptr <= dump_ptr + DMEM_AW'(1);
    end
  end

  assign imem_wen   = load_ready && load_valid;
  assign imem_addr  = 32'(load_ptr);
  assign imem_wdata = load_data;
  assign dmem_addr  = 32'(dump_ptr);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized self-checking bench for cpu_run_ctrl with a transaction-level host/memory model.
module tb_cpu_run_ctrl;

  localparam int unsigned IMEM_AW = 9;
  localparam int unsigned DMEM_AW = 10;
  localparam int unsigned CYC_W   = 32;
  localparam int IMEM_DEPTH = 1 << IMEM_AW;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  logic               clk;
  logic               rst;
  logic               start;
  logic [CYC_W-1:0]   run_cycles;
  logic [DMEM_AW:0]   dump_len;
  logic               load_valid;
  logic               load_ready;
  logic [31:0]        load_data;
  logic               load_last;
  logic               cpu_rst_n;
  logic               cpu_enable;
  logic [31:0]        imem_addr;
  logic               imem_wen;
  logic [31:0]        imem_wdata;
  logic [31:0]        dmem_addr;
  logic               dmem_ren;
  logic [31:0]        dmem_rdata;
  logic               dump_valid;
  logic               dump_ready;
  logic [31:0]        dump_data;
  logic               busy;
  logic               done;
  logic               load_ovf;

  cpu_run_ctrl #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .CYC_W(CYC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run_cycles (run_cycles),
    .dump_len   (dump_len),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_enable (cpu_enable),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_wdata (imem_wdata),
    .dmem_addr  (dmem_addr),
    .dmem_ren   (dmem_ren),
    .dmem_rdata (dmem_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done),
    .load_ovf   (load_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] prog [1024];

  // Data memory with one-cycle read latency.
  always @(posedge clk) if (dmem_ren) dmem_rdata <= dmem[dmem_addr[DMEM_AW-1:0]];

  // Running event counters; each case compares deltas.
  int   en_cnt = 0, en_rise = 0, rstn_rise_en = 0, ren_cnt = 0;
  logic en_q = 1'b0, rstn_q = 1'b0;
  always @(negedge clk) begin
    if (cpu_enable === 1'b1) en_cnt++;
    if (cpu_enable === 1'b1 && !en_q) en_rise++;
    if (cpu_rst_n === 1'b1 && !rstn_q && cpu_enable === 1'b1) rstn_rise_en++;
    if (dmem_ren === 1'b1) ren_cnt++;
    en_q   = (cpu_enable === 1'b1);
    rstn_q = (cpu_rst_n === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rst_n"},  32'(cpu_rst_n),  0);
    check({tag, "_en"},     32'(cpu_enable), 0);
    check({tag, "_lrdy"},   32'(load_ready), 0);
    check({tag, "_ren"},    32'(dmem_ren),   0);
    check({tag, "_dvalid"}, 32'(dump_valid), 0);
    check({tag, "_done"},   32'(done),       0);
    check({tag, "_busy"},   32'(busy),       0);
    check({tag, "_ovf"},    32'(load_ovf),   0);
  endtask

  // vmode: 0 always valid, 1 toggling 1010.., 2 random. rmode: 0 ready, 1 random.
  task automatic run_case(input int n, input int last, input int r, input int len,
                          input int vmode, input int rmode,
                          input int stall_word, input int stall_len,
                          input bit inject, input bit fixed_abc);
    int acc, nd, idx, k, st, c, budget;
    int e0, er0, rr0, q0;
    bit exp_ovf, tog, injected;

    for (int i = 0; i < n; i++) prog[i] = $urandom;
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = $urandom;
    if (fixed_abc) begin
      dmem[0] = 32'hA; dmem[1] = 32'hB; dmem[2] = 32'hC;
    end
    acc = (last >= 0 && last < n) ? last + 1 : n;
    if (acc > IMEM_DEPTH) acc = IMEM_DEPTH;
    exp_ovf = (acc == IMEM_DEPTH) && (last != IMEM_DEPTH - 1);
    nd = (len > DMEM_DEPTH) ? DMEM_DEPTH : len;
    e0 = en_cnt; er0 = en_rise; rr0 = rstn_rise_en; q0 = ren_cnt;

    @(negedge clk);
    start = 1'b1; run_cycles = CYC_W'(r); dump_len = (DMEM_AW + 1)'(len);
    @(negedge clk);
    start = 1'b0; run_cycles = $urandom; dump_len = (DMEM_AW + 1)'($urandom);
    check("busy_start", 32'(busy), 1);
    check("done_clr", 32'(done), 0);
    check("ovf_clr", 32'(load_ovf), 0);

    idx = 0; c = 0; tog = 1'b1; budget = 4 * acc + 20;
    while (idx < acc && c < budget) begin
      case (vmode)
        0:       load_valid = 1'b1;
        1:       load_valid = tog;
        default: load_valid = ($urandom_range(0, 3) != 0);
      endcase
      tog = !tog;
      load_data = prog[idx];
      load_last = (idx == last);
      #1;
      check("load_ready", 32'(load_ready), 1);
      if (load_valid) begin
        check("imem_wen", 32'(imem_wen), 1);
        check("imem_addr", imem_addr, idx);
        check("imem_wdata", imem_wdata, prog[idx]);
        idx++;
      end else begin
        check("imem_wen_idle", 32'(imem_wen), 0);
      end
      @(negedge clk); c++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("load_count", idx, acc);
    check("load_ready_off", 32'(load_ready), 0);
    check("load_ovf", 32'(load_ovf), 32'(exp_ovf));

    k = 0; st = 0; c = 0; injected = 1'b0;
    budget = r + 12 * nd + stall_len + 40;
    while (k < nd && c < budget) begin
      start = 1'b0;
      if (k == stall_word && st < stall_len) dump_ready = 1'b0;
      else dump_ready = rmode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (dump_valid) begin
        check("dump_data", dump_data, dmem[k]);
        if (dump_ready) k++;
        else if (k == stall_word) st++;
        if (inject && !injected && k < nd - 1) begin
          start = 1'b1; run_cycles = 99; dump_len = 1; injected = 1'b1;
        end
      end
      @(negedge clk); c++;
    end
    start = 1'b0; dump_ready = 1'b0;
    check("dump_count", k, nd);
    if (nd > 0) check("done_after_last", 32'(done), 1);

    c = 0;
    while (!done && c < r + 20) begin
      @(negedge clk); c++;
    end
    check("done", 32'(done), 1);
    check("busy_done", 32'(busy), 0);
    check("rst_n_done", 32'(cpu_rst_n), 1);
    check("en_done", 32'(cpu_enable), 0);
    check("dvalid_done", 32'(dump_valid), 0);
    check("ovf_hold", 32'(load_ovf), 32'(exp_ovf));
    check("en_cycles", en_cnt - e0, r);
    check("en_rises", en_rise - er0, 32'(r > 0));
    check("rstn_with_en", rstn_rise_en - rr0, 32'(r > 0));
    check("dmem_reads", ren_cnt - q0, nd);
  endtask

  task automatic reset_mid_dump();
    int c;
    @(negedge clk);
    start = 1'b1; run_cycles = 2; dump_len = 5;
    @(negedge clk);
    start = 1'b0;
    load_valid = 1'b1; load_data = $urandom; load_last = 1'b1;
    #1;
    check("rm_load_ready", 32'(load_ready), 1);
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0; dump_ready = 1'b0;
    c = 0;
    while (!dump_valid && c < 40) begin
      @(negedge clk); c++;
    end
    check("rm_reach_dump", 32'(dump_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rm_first");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rm_after");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; run_cycles = '0; dump_len = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    run_case(4, 3, 7, 3, 1, 0, 1, 5, 1'b0, 1'b1);
    run_case(2, 1, 0, 0, 0, 0, -1, 0, 1'b0, 1'b0);
    run_case(IMEM_DEPTH + 3, -1, 3, 2, 2, 1, -1, 0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_in_done");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(1, 24);
      run_case(n, n - 1, $urandom_range(0, 15), $urandom_range(0, 8), 2, 1,
               -1, 0, (i % 2) == 0, 1'b0);
    end

    run_case(1, 0, 1, 2047, 0, 0, -1, 0, 1'b0, 1'b0);
    run_case(IMEM_DEPTH, IMEM_DEPTH - 1, 1, 1, 0, 0, -1, 0, 1'b0, 1'b0);
    reset_mid_dump();
    run_case(3, 2, 2, 2, 0, 1, 0, 3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
